bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/ser_pkg.sv | 20 ++
 rtl/bit_serializer.sv | 106 ++++++++++
 tb/tb_bit_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer.
// Optional parity stage enabled by defining SER_PARITY_EN.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef SER_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } ser_state_e;

  function automatic logic even_parity(
    input logic [63:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input handshake.
// Define SER_PARITY_EN to append an even-parity bit to each word.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 5,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             data_out,
  output logic             frame,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic             dout_q;
  logic             frame_q;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  logic             last_bit;
  logic             fire;
  logic             first_bit;
  logic             nxt_bit;
  logic [WIDTH-1:0] sh_d;

  // The register shifts toward the bit being sent, so
  // the next bit always sits right beside the current one.
  assign sh_d      = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
  assign nxt_bit   = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
  assign first_bit = MSB_FIRST ? in_data[WIDTH-1]
                               : in_data[0];

`ifdef SER_PARITY_EN
  assign last_bit = (state_q == ST_PARITY);
`else
  assign last_bit = (state_q == ST_DATA) &&
                    (cnt_q == LAST);
`endif

  assign in_ready = !rst &&
                    ((state_q == ST_IDLE) || last_bit);
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= IDLE_LEVEL;
      frame_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (fire) begin
      state_q <= ST_DATA;
      cnt_q   <= '0;
      sh_q    <= in_data;
      dout_q  <= first_bit;
      frame_q <= 1'b1;
`ifdef SER_PARITY_EN
      par_q   <= even_parity(64'(in_data));
`endif
    end else begin
      frame_q <= 1'b0;
      unique case (state_q)
        ST_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            state_q <= ST_PARITY;
            dout_q  <= par_q;
`else
            state_q <= ST_IDLE;
            dout_q  <= IDLE_LEVEL;
`endif
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            sh_q   <= sh_d;
            dout_q <= nxt_bit;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dout_q  <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign frame    = frame_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two serializer configurations checked
// against a queue-of-pending-bits reference model.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic       va, vb;
  logic [4:0] da;
  logic [7:0] db;
  logic       rdy_a, do_a, fr_a, bz_a;
  logic       rdy_b, do_b, fr_b, bz_b;

  int total = 0;
  int bad   = 0;

  bit_serializer #(
    .WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(va), .in_ready(rdy_a), .in_data(da),
    .data_out(do_a), .frame(fr_a), .busy(bz_a)
  );

  bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(vb), .in_ready(rdy_b), .in_data(db),
    .data_out(do_b), .frame(fr_b), .busy(bz_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic f;
  } ob_t;

  ob_t qa[$];
  ob_t qb[$];

  typedef struct {
    logic       v;
    logic [4:0] d;
    logic       e_do;
    logic       e_fr;
    logic       e_bz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic v,
                              input logic [4:0] d,
                              input logic e_do,
                              input logic e_fr,
                              input logic e_bz);
    vec_t t;
    t.v = v; t.d = d;
    t.e_do = e_do; t.e_fr = e_fr; t.e_bz = e_bz;
    tbl.push_back(t);
  endfunction

  // Expand an accepted word into its send order.
  function automatic void push_word(inout ob_t q[$],
                                    input logic [63:0] w,
                                    input int wd,
                                    input bit msb);
    ob_t o;
    for (int i = 0; i < wd; i++) begin
      o.b = msb ? w[wd-1-i] : w[i];
      o.f = (i == 0);
      q.push_back(o);
    end
`ifdef SER_PARITY_EN
    o.b = ^w;
    o.f = 1'b0;
    q.push_back(o);
`endif
  endfunction

  task automatic step(input logic iva,
                      input logic [4:0] ida,
                      input logic ivb,
                      input logic [7:0] idb,
                      input logic ir);
    logic ea, eb, fa, fb;
    va = iva; da = ida;
    vb = ivb; db = idb;
    rst = ir;
    #1;
    ea = !ir && (qa.size() <= 1);
    eb = !ir && (qb.size() <= 1);
    chk("a_ready", rdy_a, ea);
    chk("a_busy", bz_a, qa.size() > 0);
    chk("a_dout", do_a, qa.size() ? qa[0].b : 1'b0);
    chk("a_frame", fr_a, qa.size() ? qa[0].f : 1'b0);
    chk("a_cnt_range", dut_a.cnt_q <= 3'd4, 1'b1);
    chk("b_ready", rdy_b, eb);
    chk("b_busy", bz_b, qb.size() > 0);
    chk("b_dout", do_b, qb.size() ? qb[0].b : 1'b1);
    chk("b_frame", fr_b, qb.size() ? qb[0].f : 1'b0);
    fa = iva && ea;
    fb = ivb && eb;
    @(posedge clk);
    if (ir) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
      if (fa) push_word(qa, 64'(ida), 5, 1'b0);
      if (fb) push_word(qb, 64'(idb), 8, 1'b1);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [7:0] eb8;
    va = 0; vb = 0; da = 0; db = 0; rst = 1;
    @(posedge clk); #1;
    step(1'b0, 5'd0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 8'd0, 1'b1);
    rst = 0;
    #1;
    chk("rst_a_dout", do_a, 1'b0);
    chk("rst_a_busy", bz_a, 1'b0);
    chk("rst_a_frame", fr_a, 1'b0);
    chk("rst_b_dout", do_b, 1'b1);
    chk("rst_b_ready", rdy_b, 1'b1);

    // Single word, then back-to-back with held valid.
`ifdef SER_PARITY_EN
    add(1, 5'b10110, 0, 1, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 0);
    add(1, 5'b10100, 0, 1, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 0, 0, 0);
`else
    add(1, 5'b10110, 0, 1, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 0);
    add(1, 5'b10110, 0, 1, 1);
    add(1, 5'b01001, 1, 0, 1);
    add(1, 5'b01001, 1, 0, 1);
    add(1, 5'b01001, 0, 0, 1);
    add(1, 5'b01001, 1, 0, 1);
    add(1, 5'b01001, 1, 1, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 1, 0, 1);
    add(0, 5'b0, 0, 0, 1);
    add(0, 5'b0, 0, 0, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, 1'b0, 8'd0, 1'b0);
      chk($sformatf("tbl%0d_dout", i), do_a, tbl[i].e_do);
      chk($sformatf("tbl%0d_frame", i), fr_a, tbl[i].e_fr);
      chk($sformatf("tbl%0d_busy", i), bz_a, tbl[i].e_bz);
    end
    idle(2);

    // Reset while bit 3 is on the line, then a clean word.
    step(1'b1, 5'b10110, 1'b0, 8'd0, 1'b0);
    idle(3);
    chk("mid_bit3", do_a, 1'b0);
    step(1'b0, 5'd0, 1'b0, 8'd0, 1'b1);
    chk("mid_rst_dout", do_a, 1'b0);
    chk("mid_rst_busy", bz_a, 1'b0);
    step(1'b1, 5'b01101, 1'b0, 8'd0, 1'b0);
    chk("post_rst_frame", fr_a, 1'b1);
    idle(8);

    // MSB-first 8-bit word.
    eb8 = 8'hA5;
    step(1'b0, 5'd0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i), do_b, eb8[7-i]);
      step(1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
    end
    idle(3);

    // Idle-high line for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
      chk("idle_b_dout", do_b, 1'b1);
      chk("idle_b_ready", rdy_b, 1'b1);
      chk("idle_b_busy", bz_b, 1'b0);
    end

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom),
           $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 59) == 0);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
